io_channel_unit: RTL and testbench

Parametrised I/O channel controller between the Backend and the core's external port interface. It replaces the direct pass-through of in/out request lines with two paths. Reads are a blocking handshake with registered return data. Writes go into an OUT_DEPTH-entry posted-write buffer, so the Backend does not stall on slow output channels. Reads are ordered behind all earlier writes, and an optional watchdog aborts transfers that are never acknowledged.

---
 rtl/io_pkg.sv | 22 ++
 rtl/io_out_fifo.sv | 63 ++++++
 rtl/io_channel_unit.sv | 184 ++++++++++++++++++
 tb/tb_io_channel_unit.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared types and defaults for the I/O channel controller.
//   - rd_state_e  : read-path FSM states (IDLE, DRAIN, REQ)
//   - D_WIDTH_DEF / PA_WIDTH_DEF : default data and port-address widths
//   - out_entry_t : one posted-write buffer entry {addr, data} at default widths
package io_pkg;

  localparam int D_WIDTH_DEF  = 34;
  localparam int PA_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_REQ   = 2'd2
  } rd_state_e;

  // Layout matches the {addr, data} concatenation stored in io_out_fifo.
  typedef struct packed {
    logic [PA_WIDTH_DEF-1:0] addr;
    logic [D_WIDTH_DEF-1:0]  data;
  } out_entry_t;

endpackage

// File: rtl/io_out_fifo.sv
// io_out_fifo: posted-write buffer with DEPTH entries of WIDTH bits.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, wdata  : write an entry (caller guarantees !full)
//   pop          : drop the head entry (caller guarantees !empty)
//   rdata        : head entry, combinational; zero while empty
//   count        : occupancy 0..DEPTH
//   full, empty  : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module io_out_fifo
  import io_pkg::*;
#(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));
  // Gate the head so the outputs read zero while nothing is buffered.
  assign rdata = empty ? '0 : mem_r[rd_ptr_r];

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/io_channel_unit.sv
// io_channel_unit: I/O channel controller between the Backend and the
// external port interface.
//   Read path : blocking handshake (IDLE -> [DRAIN] -> REQ), registered data,
//               one-cycle be_in_valid_o pulse; ordered behind buffered writes.
//   Write path: OUT_DEPTH-entry posted-write buffer (io_out_fifo) draining to
//               out_req_o/out_addr_o/out_data_o with out_ack_i.
//   Ports: clk, reset_n_i (async active-low); be_in_* read side; be_out_*
//          write side; in_* external read; out_* external write;
//          out_count_o occupancy; err_o sticky timeout flag, err_clr_i clear.
// Optional feature: define IO_TIMEOUT_EN to add a watchdog that aborts a read
// or drops a write head after TIMEOUT cycles without acknowledge.
module io_channel_unit
  import io_pkg::*;
#(
  parameter int D_WIDTH   = D_WIDTH_DEF,
  parameter int PA_WIDTH  = PA_WIDTH_DEF,
  parameter int OUT_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        reset_n_i,
  input  logic                        be_in_req_i,
  input  logic [PA_WIDTH-1:0]         be_in_addr_i,
  output logic [D_WIDTH-1:0]          be_in_data_o,
  output logic                        be_in_valid_o,
  output logic                        be_in_busy_o,
  input  logic                        be_out_req_i,
  input  logic [PA_WIDTH-1:0]         be_out_addr_i,
  input  logic [D_WIDTH-1:0]          be_out_data_i,
  output logic                        be_out_ready_o,
  output logic                        in_req_o,
  output logic [PA_WIDTH-1:0]         in_addr_o,
  input  logic [D_WIDTH-1:0]          in_data_i,
  input  logic                        in_ack_i,
  output logic                        out_req_o,
  output logic [PA_WIDTH-1:0]         out_addr_o,
  output logic [D_WIDTH-1:0]          out_data_o,
  input  logic                        out_ack_i,
  output logic [$clog2(OUT_DEPTH):0]  out_count_o,
  output logic                        err_o,
  input  logic                        err_clr_i
);

  localparam int EW = PA_WIDTH + D_WIDTH;

  rd_state_e           state_r;
  logic [PA_WIDTH-1:0] addr_r;
  logic [D_WIDTH-1:0]  rdata_r;
  logic                valid_r;

  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                pop_s;
  logic                rd_ack_s;
  logic                rd_tmo_s;
  logic                wr_tmo_s;
  logic [EW-1:0]       head_s;

  // Writes freeze while a read is pending so the read cannot be starved.
  assign be_out_ready_o = !full_s && (state_r == ST_IDLE);
  assign push_s         = be_out_req_i && be_out_ready_o;
  assign out_req_o      = !empty_s;
  assign pop_s          = out_req_o && (out_ack_i || wr_tmo_s);
  assign out_addr_o     = head_s[EW-1 -: PA_WIDTH];
  assign out_data_o     = head_s[D_WIDTH-1:0];

  assign in_req_o       = (state_r == ST_REQ);
  assign in_addr_o      = in_req_o ? addr_r : '0;
  assign rd_ack_s       = in_req_o && in_ack_i;
  assign be_in_busy_o   = (state_r != ST_IDLE);
  assign be_in_data_o   = rdata_r;
  assign be_in_valid_o  = valid_r;

  io_out_fifo #(
    .WIDTH (EW),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst_n (reset_n_i),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({be_out_addr_i, be_out_data_i}),
    .rdata (head_s),
    .count (out_count_o),
    .full  (full_s),
    .empty (empty_s)
  );

  // Read FSM: latch address, wait for earlier writes to drain, then handshake.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= ST_IDLE;
      addr_r  <= '0;
      rdata_r <= '0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (be_in_req_i) begin
            addr_r  <= be_in_addr_i;
            // A write pushed in this same cycle is older than the read.
            state_r <= (!empty_s || push_s) ? ST_DRAIN : ST_REQ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          state_r <= empty_s ? ST_REQ : ST_DRAIN;
        end
        ST_REQ: begin
          if (rd_ack_s) begin
            rdata_r <= in_data_i;
            valid_r <= 1'b1;
            state_r <= ST_IDLE;
          end else if (rd_tmo_s) begin
            rdata_r <= '0;
            valid_r <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_REQ;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef IO_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_r;
  logic            err_r;
  logic            rd_wait_s;
  logic            wr_wait_s;
  logic            wd_hit_s;
  logic            enter_req_s;

  assign rd_wait_s   = in_req_o && !in_ack_i;
  assign wr_wait_s   = out_req_o && !out_ack_i;
  assign enter_req_s = ((state_r == ST_IDLE) && be_in_req_i && empty_s && !push_s) ||
                       ((state_r == ST_DRAIN) && empty_s);
  // The cycle that would bring the count to TIMEOUT is the abort cycle, so a
  // request unacknowledged for TIMEOUT cycles completes on the next one.
  assign wd_hit_s    = (rd_wait_s || wr_wait_s) && (wd_r == WD_W'(TIMEOUT - 1));
  assign rd_tmo_s    = rd_wait_s && wd_hit_s;
  assign wr_tmo_s    = wr_wait_s && wd_hit_s && !rd_tmo_s;
  assign err_o       = err_r;

  // Watchdog: counts waiting cycles; idle cycles also clear it so a new
  // transfer never inherits a stale count.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wd_r <= '0;
    end else if (enter_req_s || pop_s || !(rd_wait_s || wr_wait_s)) begin
      wd_r <= '0;
    end else begin
      wd_r <= wd_r + WD_W'(1);
    end
  end

  // Sticky error flag; a new timeout wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_r <= 1'b0;
    end else if (rd_tmo_s || wr_tmo_s) begin
      err_r <= 1'b1;
    end else if (err_clr_i) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end
`else
  logic unused_s;

  assign rd_tmo_s = 1'b0;
  assign wr_tmo_s = 1'b0;
  assign err_o    = 1'b0;
  assign unused_s = err_clr_i ^ (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_io_channel_unit.sv
// Self-checking bench for io_channel_unit: scoreboard queues hold expected
// read data and expected write-buffer heads; each scenario task compares
// DUT outputs against them (and against constants) one cycle at a time.
module tb_io_channel_unit;
  import io_pkg::*;

  localparam int D_WIDTH   = 34;
  localparam int PA_WIDTH  = 4;
  localparam int OUT_DEPTH = 4;
  localparam int TIMEOUT   = 8;
  localparam int CW        = $clog2(OUT_DEPTH) + 1;

  logic                clk = 1'b0;
  logic                reset_n_i;
  logic                be_in_req_i;
  logic [PA_WIDTH-1:0] be_in_addr_i;
  logic [D_WIDTH-1:0]  be_in_data_o;
  logic                be_in_valid_o;
  logic                be_in_busy_o;
  logic                be_out_req_i;
  logic [PA_WIDTH-1:0] be_out_addr_i;
  logic [D_WIDTH-1:0]  be_out_data_i;
  logic                be_out_ready_o;
  logic                in_req_o;
  logic [PA_WIDTH-1:0] in_addr_o;
  logic [D_WIDTH-1:0]  in_data_i;
  logic                in_ack_i;
  logic                out_req_o;
  logic [PA_WIDTH-1:0] out_addr_o;
  logic [D_WIDTH-1:0]  out_data_o;
  logic                out_ack_i;
  logic [CW-1:0]       out_count_o;
  logic                err_o;
  logic                err_clr_i;

  int checks   = 0;
  int failures = 0;

  logic [D_WIDTH-1:0] rd_exp_q [$];
  out_entry_t         wr_exp_q [$];

  always #5 clk = ~clk;

  io_channel_unit #(
    .D_WIDTH   (D_WIDTH),
    .PA_WIDTH  (PA_WIDTH),
    .OUT_DEPTH (OUT_DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset_n_i      (reset_n_i),
    .be_in_req_i    (be_in_req_i),
    .be_in_addr_i   (be_in_addr_i),
    .be_in_data_o   (be_in_data_o),
    .be_in_valid_o  (be_in_valid_o),
    .be_in_busy_o   (be_in_busy_o),
    .be_out_req_i   (be_out_req_i),
    .be_out_addr_i  (be_out_addr_i),
    .be_out_data_i  (be_out_data_i),
    .be_out_ready_o (be_out_ready_o),
    .in_req_o       (in_req_o),
    .in_addr_o      (in_addr_o),
    .in_data_i      (in_data_i),
    .in_ack_i       (in_ack_i),
    .out_req_o      (out_req_o),
    .out_addr_o     (out_addr_o),
    .out_data_o     (out_data_o),
    .out_ack_i      (out_ack_i),
    .out_count_o    (out_count_o),
    .err_o          (err_o),
    .err_clr_i      (err_clr_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    be_in_req_i   = 1'b0;
    be_in_addr_i  = '0;
    be_out_req_i  = 1'b0;
    be_out_addr_i = '0;
    be_out_data_i = '0;
    in_data_i     = '0;
    in_ack_i      = 1'b0;
    out_ack_i     = 1'b0;
    err_clr_i     = 1'b0;
  endtask

  // Drive one write request this cycle; record it if the DUT will accept it.
  task automatic drive_write(input logic [PA_WIDTH-1:0] a, input logic [D_WIDTH-1:0] d);
    be_out_req_i  = 1'b1;
    be_out_addr_i = a;
    be_out_data_i = d;
    if (be_out_ready_o) wr_exp_q.push_back('{addr: a, data: d});
  endtask

  // Acknowledge every buffered write, comparing each head against the scoreboard.
  task automatic drain_writes();
    out_entry_t exp;
    int n = 0;
    while (out_req_o && n < 16) begin
      exp = (wr_exp_q.size() > 0) ? wr_exp_q.pop_front() : '0;
      checks++;
      if ({out_addr_o, out_data_o} !== exp) begin
        failures++;
        $display("FAIL drain_head got %h expected %h", {out_addr_o, out_data_o}, exp);
      end
      out_ack_i = 1'b1;
      tick();
      out_ack_i = 1'b0;
      n++;
    end
    checks++;
    if (out_count_o !== CW'(0) || wr_exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_empty count=%0d left=%0d expected 0/0", out_count_o, wr_exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    idle_inputs();
    repeat (2) tick();
    checks++;
    if ({in_req_o, out_req_o, be_in_valid_o, be_in_busy_o, err_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got %b expected 00000",
               {in_req_o, out_req_o, be_in_valid_o, be_in_busy_o, err_o});
    end
    checks++;
    if (be_out_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b expected 1", be_out_ready_o);
    end
    checks++;
    if (out_count_o !== CW'(0) || be_in_data_o !== '0 || in_addr_o !== '0 || out_data_o !== '0) begin
      failures++;
      $display("FAIL reset_values count=%0d data=%h in_addr=%h out_data=%h expected all 0",
               out_count_o, be_in_data_o, in_addr_o, out_data_o);
    end
    reset_n_i = 1'b1;
    tick();
  endtask

  task automatic test_read();
    logic [D_WIDTH-1:0] exp;
    be_in_req_i  = 1'b1;
    be_in_addr_i = 4'd3;
    tick();
    be_in_req_i  = 1'b0;
    checks++;
    if (in_req_o !== 1'b1 || in_addr_o !== 4'd3) begin
      failures++;
      $display("FAIL read_req cycle1 got req=%b addr=%0d expected 1/3", in_req_o, in_addr_o);
    end
    checks++;
    if (be_out_ready_o !== 1'b0 || be_in_busy_o !== 1'b1) begin
      failures++;
      $display("FAIL read_busy got ready=%b busy=%b expected 0/1", be_out_ready_o, be_in_busy_o);
    end
    tick();
    in_ack_i  = 1'b1;
    in_data_i = 34'h2_0000_0001;
    rd_exp_q.push_back(in_data_i);
    checks++;
    if (be_in_valid_o !== 1'b0 || in_addr_o !== 4'd3) begin
      failures++;
      $display("FAIL read_cycle2 got valid=%b addr=%0d expected 0/3", be_in_valid_o, in_addr_o);
    end
    tick();
    in_ack_i = 1'b0;
    checks++;
    if (be_in_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL read_valid cycle3 got %b expected 1", be_in_valid_o);
    end
    exp = (rd_exp_q.size() > 0) ? rd_exp_q.pop_front() : '0;
    checks++;
    if (be_in_data_o !== exp) begin
      failures++;
      $display("FAIL read_data got %h expected %h", be_in_data_o, exp);
    end
    tick();
    checks++;
    if (be_in_valid_o !== 1'b0 || be_in_busy_o !== 1'b0 || be_in_data_o !== 34'h2_0000_0001) begin
      failures++;
      $display("FAIL read_after got valid=%b busy=%b data=%h expected 0/0/200000001",
               be_in_valid_o, be_in_busy_o, be_in_data_o);
    end
  endtask

  task automatic test_write_fill();
    for (int i = 0; i < 4; i++) begin
      drive_write(PA_WIDTH'(i + 1), D_WIDTH'(10 + i));
      tick();
    end
    be_out_req_i = 1'b0;
    checks++;
    if (out_count_o !== CW'(4) || be_out_ready_o !== 1'b0 || out_req_o !== 1'b1) begin
      failures++;
      $display("FAIL fill_full got count=%0d ready=%b req=%b expected 4/0/1",
               out_count_o, be_out_ready_o, out_req_o);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_addr_o !== PA_WIDTH'(i + 1) || out_data_o !== D_WIDTH'(10 + i)) begin
        failures++;
        $display("FAIL fill_order[%0d] got %0d/%0d expected %0d/%0d",
                 i, out_addr_o, out_data_o, i + 1, 10 + i);
      end
      void'(wr_exp_q.pop_front());
      out_ack_i = 1'b1;
      tick();
    end
    out_ack_i = 1'b0;
    checks++;
    if (out_count_o !== CW'(0) || out_req_o !== 1'b0) begin
      failures++;
      $display("FAIL fill_drained got count=%0d req=%b expected 0/0", out_count_o, out_req_o);
    end
  endtask

  task automatic test_read_after_write();
    out_entry_t         wexp;
    logic [D_WIDTH-1:0] rexp;
    int                 n;
    drive_write(4'd5, 34'h55);
    be_in_req_i  = 1'b1;
    be_in_addr_i = 4'd5;
    tick();
    idle_inputs();
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (in_req_o !== 1'b0 || be_out_ready_o !== 1'b0 || be_in_busy_o !== 1'b1) begin
        failures++;
        $display("FAIL order_hold c%0d got in_req=%b ready=%b busy=%b expected 0/0/1",
                 c, in_req_o, be_out_ready_o, be_in_busy_o);
      end
      if (c == 3) begin
        wexp = (wr_exp_q.size() > 0) ? wr_exp_q.pop_front() : '0;
        checks++;
        if ({out_addr_o, out_data_o} !== wexp) begin
          failures++;
          $display("FAIL order_head got %h expected %h", {out_addr_o, out_data_o}, wexp);
        end
        out_ack_i = 1'b1;
      end
      tick();
    end
    out_ack_i = 1'b0;
    checks++;
    if (in_req_o !== 1'b0 || out_count_o !== CW'(0)) begin
      failures++;
      $display("FAIL order_popped got in_req=%b count=%0d expected 0/0", in_req_o, out_count_o);
    end
    n = 0;
    while (!in_req_o && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (in_req_o !== 1'b1 || in_addr_o !== 4'd5 || n != 1) begin
      failures++;
      $display("FAIL order_req got req=%b addr=%0d wait=%0d expected 1/5/1", in_req_o, in_addr_o, n);
    end
    in_ack_i  = 1'b1;
    in_data_i = 34'h3_1234_5678;
    rd_exp_q.push_back(in_data_i);
    tick();
    in_ack_i = 1'b0;
    rexp = (rd_exp_q.size() > 0) ? rd_exp_q.pop_front() : '0;
    checks++;
    if (be_in_valid_o !== 1'b1 || be_in_data_o !== rexp) begin
      failures++;
      $display("FAIL order_read got valid=%b data=%h expected 1/%h", be_in_valid_o, be_in_data_o, rexp);
    end
    tick();
  endtask

  task automatic test_push_pop_wrap();
    out_entry_t exp;
    drive_write(4'd6, 34'h60);
    tick();
    drive_write(4'd7, 34'h61);
    tick();
    be_out_req_i = 1'b0;
    checks++;
    if (out_count_o !== CW'(2)) begin
      failures++;
      $display("FAIL pp_before got count=%0d expected 2", out_count_o);
    end
    exp = (wr_exp_q.size() > 0) ? wr_exp_q.pop_front() : '0;
    checks++;
    if ({out_addr_o, out_data_o} !== exp) begin
      failures++;
      $display("FAIL pp_head got %h expected %h", {out_addr_o, out_data_o}, exp);
    end
    drive_write(4'd8, 34'h62);
    out_ack_i = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (out_count_o !== CW'(2)) begin
      failures++;
      $display("FAIL pp_after got count=%0d expected 2", out_count_o);
    end
    drain_writes();
    // Ten streamed transfers walk the pointers around the buffer several times.
    for (int i = 0; i < 10; i++) begin
      if (out_req_o) begin
        exp = (wr_exp_q.size() > 0) ? wr_exp_q.pop_front() : '0;
        checks++;
        if ({out_addr_o, out_data_o} !== exp) begin
          failures++;
          $display("FAIL wrap_head[%0d] got %h expected %h", i, {out_addr_o, out_data_o}, exp);
        end
        out_ack_i = 1'b1;
      end else begin
        out_ack_i = 1'b0;
      end
      drive_write(PA_WIDTH'(i), D_WIDTH'($urandom));
      tick();
    end
    idle_inputs();
    drain_writes();
  endtask

`ifdef IO_TIMEOUT_EN
  task automatic test_timeout();
    be_in_req_i  = 1'b1;
    be_in_addr_i = 4'd7;
    tick();
    be_in_req_i  = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (be_in_valid_o !== (c == 9)) begin
        failures++;
        $display("FAIL tmo_valid c%0d got %b expected %b", c, be_in_valid_o, (c == 9));
      end
      if (c == 9) begin
        checks++;
        if (be_in_data_o !== '0 || err_o !== 1'b1) begin
          failures++;
          $display("FAIL tmo_result got data=%h err=%b expected 0/1", be_in_data_o, err_o);
        end
      end
      tick();
    end
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear got %b expected 0", err_o);
    end
    // Second timeout with clear held high the whole time: the set must win.
    be_in_req_i  = 1'b1;
    be_in_addr_i = 4'd7;
    err_clr_i    = 1'b1;
    tick();
    be_in_req_i  = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 8 || c == 9) begin
        checks++;
        if (err_o !== (c == 9)) begin
          failures++;
          $display("FAIL tmo_setclr c%0d got %b expected %b", c, err_o, (c == 9));
        end
      end
      tick();
    end
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    // Write never acknowledged: head dropped after TIMEOUT waiting cycles.
    drive_write(4'd9, 34'h99);
    tick();
    be_out_req_i = 1'b0;
    void'(wr_exp_q.pop_front());
    for (int c = 1; c <= 9; c++) begin
      if (c == 8 || c == 9) begin
        checks++;
        if (out_count_o !== ((c == 9) ? CW'(0) : CW'(1)) || err_o !== (c == 9)) begin
          failures++;
          $display("FAIL tmo_write c%0d got count=%0d err=%b expected %0d/%b",
                   c, out_count_o, err_o, (c == 9) ? 0 : 1, (c == 9));
        end
      end
      tick();
    end
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    drive_write(4'd1, 34'h1);
    tick();
    drive_write(4'd2, 34'h2);
    tick();
    be_out_req_i = 1'b0;
    be_in_req_i  = 1'b1;
    be_in_addr_i = 4'd2;
    tick();
    be_in_req_i  = 1'b0;
    checks++;
    if (be_in_busy_o !== 1'b1 || out_count_o !== CW'(2) || out_req_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup got busy=%b count=%0d req=%b expected 1/2/1",
               be_in_busy_o, out_count_o, out_req_o);
    end
    #2 reset_n_i = 1'b0;
    #1;
    checks++;
    if (in_req_o !== 1'b0 || out_req_o !== 1'b0 || out_count_o !== CW'(0) || be_in_busy_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_drain got in_req=%b out_req=%b count=%0d busy=%b expected 0/0/0/0",
               in_req_o, out_req_o, out_count_o, be_in_busy_o);
    end
    wr_exp_q.delete();
    tick();
    reset_n_i = 1'b1;
    tick();
    be_in_req_i  = 1'b1;
    be_in_addr_i = 4'd4;
    tick();
    be_in_req_i  = 1'b0;
    checks++;
    if (in_req_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_req_setup got %b expected 1", in_req_o);
    end
    #2 reset_n_i = 1'b0;
    #1;
    checks++;
    if (in_req_o !== 1'b0 || in_addr_o !== '0 || be_out_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_req got req=%b addr=%0d ready=%b expected 0/0/1",
               in_req_o, in_addr_o, be_out_ready_o);
    end
    tick();
    reset_n_i = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_fill();
    test_read_after_write();
    test_push_pop_wrap();
`ifdef IO_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
